// File: rtl/key_sched_pkg.sv
// rtl/key_sched_pkg.sv - shared types and sizing constants for the key scheduler
package key_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam int KEY_W_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W     = 5;

endpackage

// File: rtl/key_sched_mem.sv
// rtl/key_sched_mem.sv - DEPTH x KEY_W key store, one sync write port, one async read port
module key_sched_mem #(
  parameter int KEY_W = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [KEY_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [KEY_W-1:0] rdata
);

  logic [KEY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Addresses beyond DEPTH exist only when DEPTH is not a power of two.
  assign rdata = ({1'b0, raddr} < (AW+1)'(DEPTH)) ? mem[raddr] : '0;

endmodule

// File: rtl/key_sched_ctrl.sv
// rtl/key_sched_ctrl.sv - key load/sequencing FSM with read pointer, epoch counter and error flag
module key_sched_ctrl
  import key_sched_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [KEY_W-1:0] cfg_data,
  input  logic             cfg_last,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             step_en,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic [CNT_W-1:0] loaded_cnt,
  output logic [7:0]       epoch,
  output logic             err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state_q, state_d;
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    ptr_nxt;
  logic [AW-1:0]    raddr;
  logic [KEY_W-1:0] rdata;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] ptr_inc;
  logic             wrap;
  logic             do_accept, do_start, do_step, do_stop, err_set;

  assign cnt_inc = loaded_cnt + CNT_W'(1);
  assign ptr_inc = CNT_W'(ptr) + CNT_W'(1);
  assign wrap    = (ptr_inc == loaded_cnt);
  assign ptr_nxt = wrap ? '0 : ptr + AW'(1);
  // On start the first key is fetched; otherwise look ahead to the next one.
  assign raddr   = (state_q == READY) ? '0 : ptr_nxt;

  key_sched_mem #(
    .KEY_W(KEY_W),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (do_accept),
    .waddr(loaded_cnt[AW-1:0]),
    .wdata(cfg_data),
    .raddr(raddr),
    .rdata(rdata)
  );

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    do_accept = 1'b0;
    do_start  = 1'b0;
    do_step   = 1'b0;
    do_stop   = 1'b0;
    err_set   = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE, LOAD: begin
          cfg_ready = 1'b1;
          if (start) err_set = 1'b1;
          if (cfg_valid) begin
            do_accept = 1'b1;
            if (cfg_last || cnt_inc == CNT_W'(DEPTH)) state_d = READY;
            else                                      state_d = LOAD;
          end
        end
        READY: begin
          if (cfg_valid || step_en) err_set = 1'b1;
          if (start && !stop) begin
            do_start = 1'b1;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (cfg_valid) err_set = 1'b1;
          if (stop) begin
            do_stop = 1'b1;
            state_d = READY;
          end else if (step_en) begin
            do_step = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      // clear pre-empts every other action in the same cycle
      if (clear) begin
        state_d   = IDLE;
        do_accept = 1'b0;
        do_start  = 1'b0;
        do_step   = 1'b0;
        do_stop   = 1'b0;
        err_set   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q    <= IDLE;
      loaded_cnt <= '0;
      ptr        <= '0;
      epoch      <= '0;
      key_out    <= '0;
      key_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (do_accept) loaded_cnt <= cnt_inc;
      if (err_set)   err        <= 1'b1;
      if (do_start) begin
        ptr       <= '0;
        key_out   <= rdata;
        key_valid <= 1'b1;
      end
      if (do_step) begin
        ptr     <= ptr_nxt;
        key_out <= rdata;
        if (wrap) epoch <= epoch + 8'd1;
      end
      if (do_stop) begin
        key_out   <= '0;
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/key_sched_ctrl.md
KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 Parameter KEY_W, default 8, width of one key word.
REQ-002 Parameter DEPTH, default 4, legal range 1..16, maximum number of stored key words.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 cfg_valid  input  1  key word offered for loading.
REQ-006 cfg_data  input  KEY_W  key word value.
REQ-007 cfg_last  input  1  marks the final word of a load.
REQ-008 cfg_ready  output  1  controller accepts a word this cycle.
REQ-009 start  input  1  begin key sequencing.
REQ-010 stop  input  1  pause sequencing; keys retained.
REQ-011 clear  input  1  discard keys; return to IDLE.
REQ-012 step_en  input  1  locked FSM advances this cycle; next key required.
REQ-013 key_out  output  KEY_W  key word presented to the locked FSM.
REQ-014 key_valid  output  1  key_out is a scheduled key.
REQ-015 loaded_cnt  output  5  number of stored key words.
REQ-016 epoch  output  8  count of completed schedule wraps, modulo 256.
REQ-017 err  output  1  sticky protocol-error flag.

Function
REQ-018 States: IDLE, LOAD, READY, RUN.
REQ-019 cfg_ready SHALL be 1 in IDLE and LOAD, and 0 in READY, in RUN and while rst is high.
REQ-020 Word accept: cfg_valid and cfg_ready -> mem[loaded_cnt] = cfg_data, loaded_cnt + 1 next cycle.
REQ-021 IDLE/LOAD, word accepted with cfg_last=1, or accepted word makes loaded_cnt == DEPTH -> READY.
REQ-022 IDLE, word accepted with cfg_last=0 and loaded_cnt+1 < DEPTH -> LOAD.
REQ-023 READY, start -> RUN.
REQ-024 On the same edge as REQ-023, the read pointer SHALL be set to 0, key_out to mem[0] and key_valid to 1, so key_out is valid one cycle after start.
REQ-025 RUN, step_en -> key_out = mem[next pointer] one cycle later.
REQ-026 Next pointer = pointer+1; when pointer+1 == loaded_cnt it SHALL be 0 instead, and epoch SHALL increment (wrapping 255->0).
REQ-027 loaded_cnt == 1 in RUN: key_out holds mem[0]; epoch increments on every step_en.
REQ-028 RUN, stop -> READY with key_valid=0, key_out=0, and pointer and epoch held.
REQ-029 A later start restarts sequencing at pointer 0; epoch is not cleared.
REQ-030 stop and step_en in the same cycle: stop wins; pointer and epoch do not advance.
REQ-031 start and stop in the same cycle in READY: start ignored.
REQ-032 clear in any state -> IDLE next cycle with loaded_cnt=0, epoch=0, key_valid=0, key_out=0; mem contents need not be cleared.
REQ-033 clear has priority over start, stop, step_en and cfg handshakes in the same cycle; a word offered that cycle is not written.
REQ-034 err SHALL set on any of:
  - start in IDLE or LOAD (start is otherwise ignored)
  - cfg_valid in READY or RUN (word dropped)
  - step_en in READY (ignored)
REQ-035 err SHALL clear only on clear or rst.
REQ-036 key_out, key_valid, loaded_cnt and epoch SHALL be registered outputs.

Reset
REQ-037 rst high at a rising edge -> state IDLE, loaded_cnt=0, pointer=0, epoch=0, key_out=0, key_valid=0, err=0.
REQ-038 rst SHALL override all other inputs, including a mid-load or mid-run operation; the first handshake is accepted in the first cycle after rst deasserts.

Structure
REQ-039 Shared package key_sched_pkg SHALL hold the state enumeration, the default KEY_W and DEPTH, and the 5-bit count width constant.
REQ-040 The key store SHALL be a separate sub-module key_sched_mem: DEPTH x KEY_W registers, one synchronous write port and one read port.
REQ-041 The FSM, pointer and epoch logic SHALL reside in key_sched_ctrl.

Verification (KEY_W=8, DEPTH=4)
REQ-042 Load A1,B2,C3 (last on C3), start, step_en held high -> key_out A1,B2,C3,A1,...; epoch 1 at the 4th key; loaded_cnt=3.
REQ-043 Load 4 words with cfg_last=0 -> READY after the 4th; cfg_ready=0; a 5th cfg_valid sets err, loaded_cnt stays 4.
REQ-044 Single word 5A, start, 3 step_en -> key_out stays 5A, epoch=3.
REQ-045 RUN at pointer 1, stop and step_en same cycle -> READY, pointer 1, key_valid=0; start -> key_out=mem[0].
REQ-046 start in IDLE -> err=1, state IDLE; clear -> err=0.
REQ-047 rst asserted mid-RUN -> next cycle all outputs 0, cfg_ready=1 after release, fresh load accepted.
